// File: rtl/memory_responder_if.sv
// Core-to-memory request/response bundle for memory_responder.
// The core drives the request side (master), the responder answers (slave).
interface memory_responder_if;
  logic        memory_enable;
  logic        memory_command;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;
  logic [3:0]  memory_write_mask;
  logic        memory_ready;
  logic        memory_valid;
  logic [31:0] memory_read_data;

  modport master (
    output memory_enable, memory_command, memory_address, memory_write_data, memory_write_mask,
    input  memory_ready, memory_valid, memory_read_data
  );

  modport slave (
    input  memory_enable, memory_command, memory_address, memory_write_data, memory_write_mask,
    output memory_ready, memory_valid, memory_read_data
  );
endinterface

// File: rtl/memory_responder.sv
// Single-port word memory answering one core request at a time with a one-cycle valid pulse.
// Define MEMORY_WAIT_STATE_EN to insert WAIT_CYCLES wait states between accept and respond.
module memory_responder #(
  parameter int unsigned WORDS       = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input logic                clk,
  input logic                reset,
  memory_responder_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(WORDS);

`ifdef MEMORY_WAIT_STATE_EN
  typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRespond} state_e;
  localparam int unsigned unused_wait_cycles = WAIT_CYCLES;
`endif

  state_e            state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_q [WORDS];
  logic              enter_respond;
  logic              mem_we;
  logic              acc_cmd;
  logic [IdxW-1:0]   acc_idx;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_mask;
  logic [IdxW-1:0]   bus_idx;
  logic              unused_addr;

  // Upper address bits wrap modulo WORDS; byte offset is ignored.
  assign bus_idx     = bus.memory_address[IdxW+1:2];
  assign unused_addr = ^{bus.memory_address[31:IdxW+2], bus.memory_address[1:0]};

`ifdef MEMORY_WAIT_STATE_EN
  logic [3:0]      cnt_q, cnt_d;
  logic            cmd_q, cmd_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      mask_q, mask_d;

  assign acc_cmd   = cmd_q;
  assign acc_idx   = idx_q;
  assign acc_wdata = wdata_q;
  assign acc_mask  = mask_q;
`else
  // Without wait states the access completes on the accept edge, straight from the bus.
  assign acc_cmd   = bus.memory_command;
  assign acc_idx   = bus_idx;
  assign acc_wdata = bus.memory_write_data;
  assign acc_mask  = bus.memory_write_mask;
`endif

  always_comb begin
    state_d       = state_q;
    enter_respond = 1'b0;
`ifdef MEMORY_WAIT_STATE_EN
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.memory_enable) begin
`ifdef MEMORY_WAIT_STATE_EN
          state_d = StWait;
          cnt_d   = 4'(WAIT_CYCLES);
          cmd_d   = bus.memory_command;
          idx_d   = bus_idx;
          wdata_d = bus.memory_write_data;
          mask_d  = bus.memory_write_mask;
`else
          state_d       = StRespond;
          enter_respond = 1'b1;
`endif
        end
      end
`ifdef MEMORY_WAIT_STATE_EN
      StWait: begin
        if (cnt_q == 4'd1) begin
          state_d       = StRespond;
          enter_respond = 1'b1;
          cnt_d         = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    if (enter_respond) begin
      if (acc_cmd) mem_we  = 1'b1;
      else         rdata_d = mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rdata_q <= 32'd0;
`ifdef MEMORY_WAIT_STATE_EN
      cnt_q   <= 4'd0;
      cmd_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
`ifdef MEMORY_WAIT_STATE_EN
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
`endif
    end
  end

  // Storage is intentionally never initialised; reset only blocks the pending commit.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_mask[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign bus.memory_ready     = (state_q == StIdle) && !reset;
  assign bus.memory_valid     = (state_q == StRespond);
  assign bus.memory_read_data = rdata_q;

endmodule
